// File: rtl/lcd1602_pkg.sv
// Shared definitions for the LCD1602 bus receiver: instruction decode,
// DDRAM address ranges, blank character, FSM states and cursor helpers.
package lcd1602_pkg;

    // Instruction classes, selected by the highest set bit of the byte
    typedef enum logic [3:0] {
        I_SET_DDRAM,
        I_SET_CGRAM,
        I_FUNC_SET,
        I_SHIFT,
        I_DISP_CTRL,
        I_ENTRY_MODE,
        I_HOME,
        I_CLEAR,
        I_NONE
    } instr_e;

    typedef enum logic [1:0] {
        ST_CLEARING = 2'd0,
        ST_IDLE     = 2'd1,
        ST_EXEC     = 2'd2
    } state_e;

    typedef struct packed {
        logic display_on;
        logic cursor_on;
        logic blink_on;
        logic mode_8bit;
        logic two_line;
        logic entry_inc;
        logic entry_shift;
    } lcd_flags_t;

    localparam lcd_flags_t FLAGS_RESET = '{display_on: 1'b0, cursor_on: 1'b0, blink_on: 1'b0,
                                           mode_8bit: 1'b1, two_line: 1'b0, entry_inc: 1'b1,
                                           entry_shift: 1'b0};

    // Opcode mask/value pairs
    localparam logic [7:0] OP_DDRAM_MASK = 8'h80, OP_DDRAM_VAL = 8'h80;
    localparam logic [7:0] OP_CGRAM_MASK = 8'hC0, OP_CGRAM_VAL = 8'h40;
    localparam logic [7:0] OP_FUNC_MASK  = 8'hE0, OP_FUNC_VAL  = 8'h20;
    localparam logic [7:0] OP_SHIFT_MASK = 8'hF0, OP_SHIFT_VAL = 8'h10;
    localparam logic [7:0] OP_DISP_MASK  = 8'hF8, OP_DISP_VAL  = 8'h08;
    localparam logic [7:0] OP_ENTRY_MASK = 8'hFC, OP_ENTRY_VAL = 8'h04;
    localparam logic [7:0] OP_HOME_MASK  = 8'hFE, OP_HOME_VAL  = 8'h02;
    localparam logic [7:0] OP_CLEAR_VAL  = 8'h01;

    // DDRAM address bounds for the two rows
    localparam logic [6:0] DDRAM_ROW0_MIN = 7'h00;
    localparam logic [6:0] DDRAM_ROW0_MAX = 7'h27;
    localparam logic [6:0] DDRAM_ROW1_MIN = 7'h40;
    localparam logic [6:0] DDRAM_ROW1_MAX = 7'h67;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    function automatic instr_e decode_instr(input logic [7:0] b);
        instr_e r;
        if ((b & OP_DDRAM_MASK) == OP_DDRAM_VAL)      r = I_SET_DDRAM;
        else if ((b & OP_CGRAM_MASK) == OP_CGRAM_VAL) r = I_SET_CGRAM;
        else if ((b & OP_FUNC_MASK) == OP_FUNC_VAL)   r = I_FUNC_SET;
        else if ((b & OP_SHIFT_MASK) == OP_SHIFT_VAL) r = I_SHIFT;
        else if ((b & OP_DISP_MASK) == OP_DISP_VAL)   r = I_DISP_CTRL;
        else if ((b & OP_ENTRY_MASK) == OP_ENTRY_VAL) r = I_ENTRY_MODE;
        else if ((b & OP_HOME_MASK) == OP_HOME_VAL)   r = I_HOME;
        else if (b == OP_CLEAR_VAL)                   r = I_CLEAR;
        else                                          r = I_NONE;
        return r;
    endfunction

    function automatic logic ddram_valid(input logic [6:0] a);
        return (a <= DDRAM_ROW0_MAX) || ((a >= DDRAM_ROW1_MIN) && (a <= DDRAM_ROW1_MAX));
    endfunction

    // Row 0 end continues on row 1; row 1 end wraps to the start of row 0
    function automatic logic [6:0] cursor_inc(input logic [6:0] a);
        logic [6:0] r;
        if (a == DDRAM_ROW0_MAX)      r = DDRAM_ROW1_MIN;
        else if (a == DDRAM_ROW1_MAX) r = DDRAM_ROW0_MIN;
        else                          r = a + 7'd1;
        return r;
    endfunction

    function automatic logic [6:0] cursor_dec(input logic [6:0] a);
        logic [6:0] r;
        if (a == DDRAM_ROW0_MIN)      r = DDRAM_ROW1_MAX;
        else if (a == DDRAM_ROW1_MIN) r = DDRAM_ROW0_MAX;
        else                          r = a - 7'd1;
        return r;
    endfunction

endpackage

// File: rtl/lcd1602_bus_receiver_if.sv
// HD44780-style parallel bus: the controller drives it, the receiver watches it.
interface lcd1602_bus_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 lcd_rs;
    logic                 lcd_rw;
    logic                 lcd_enable;
    logic [DATA_BITS-1:0] lcd_data;

    modport master (output lcd_rs, output lcd_rw, output lcd_enable, output lcd_data);
    modport slave  (input  lcd_rs, input  lcd_rw, input  lcd_enable, input  lcd_data);
endinterface

// File: rtl/lcd_bus_sync.sv
// Synchronizer chain for the asynchronous LCD bus plus enable falling-edge
// detect. rs/rw/data are taken from the sample just before enable dropped.
module lcd_bus_sync #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lcd_rs,
    input  logic                 lcd_rw,
    input  logic                 lcd_enable,
    input  logic [DATA_BITS-1:0] lcd_data,
    output logic                 strobe,
    output logic                 rs,
    output logic                 rw,
    output logic [DATA_BITS-1:0] data
);
    localparam int W = DATA_BITS + 3;

    logic [W-1:0] sync_r [SYNC_STAGES];
    logic [W-1:0] prev_r;

    // Shift bus samples through the synchronizer, keep one older sample
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= {W{1'b0}};
            prev_r <= {W{1'b0}};
        end else begin
            sync_r[0] <= {lcd_enable, lcd_rw, lcd_rs, lcd_data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign strobe = prev_r[W-1] & ~sync_r[SYNC_STAGES-1][W-1];
    assign rw     = prev_r[W-2];
    assign rs     = prev_r[W-3];
    assign data   = prev_r[DATA_BITS-1:0];

endmodule

// File: rtl/lcd1602_bus_receiver.sv
// LCD1602 bus responder: decodes instructions and character writes from the
// controller and keeps a 2x16 shadow DDRAM, cursor and mode flags.
// Optional busy-timing checker enabled by defining LCD_RX_BUSY_CHECK_EN.
module lcd1602_bus_receiver
    import lcd1602_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int NUM_COLS    = 16,
    parameter int NUM_ROWS    = 2,
    parameter int SYNC_STAGES = 2
`ifdef LCD_RX_BUSY_CHECK_EN
    ,
    parameter int BUSY_CYCLES       = 2000,
    parameter int BUSY_CYCLES_CLEAR = 80000
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    lcd1602_bus_receiver_if.slave      bus,
    input  logic [4:0]                 rd_addr,
    output logic [7:0]                 rd_char,
    output logic [6:0]                 cursor_addr,
    output logic                       display_on,
    output logic                       cursor_on,
    output logic                       blink_on,
    output logic                       mode_8bit,
    output logic                       two_line,
    output logic                       entry_inc,
    output logic                       entry_shift,
    output logic                       cmd_valid,
    output logic [7:0]                 cmd_code,
    output logic                       data_valid,
    output logic                       unsupported,
    output logic                       dropped,
    output logic                       protocol_err
);
    localparam int CELLS  = NUM_COLS * NUM_ROWS;
    localparam int CELL_W = $clog2(CELLS);

    logic                 strb_s, rs_s, rw_s;
    logic [DATA_BITS-1:0] data_s;
    state_e               state_r, state_nxt_s;
    instr_e               instr_s;
    logic [CELL_W-1:0]    clr_idx_r;
    logic                 clr_req_r, clr_req_nxt_s;
    lcd_flags_t           flags_r, flags_nxt_s;
    logic [6:0]           cursor_nxt_s;
    logic [7:0]           cmd_code_nxt_s;
    logic                 cmd_valid_nxt_s, data_valid_nxt_s, unsup_nxt_s, dropped_nxt_s;
    logic                 ram_we_s;
    logic [CELL_W-1:0]    ram_waddr_s;
    logic [7:0]           ram_wdata_s;
    logic [7:0]           ram_r [CELLS];

    lcd_bus_sync #(.DATA_BITS(DATA_BITS), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .reset      (reset),
        .lcd_rs     (bus.lcd_rs),
        .lcd_rw     (bus.lcd_rw),
        .lcd_enable (bus.lcd_enable),
        .lcd_data   (bus.lcd_data),
        .strobe     (strb_s),
        .rs         (rs_s),
        .rw         (rw_s),
        .data       (data_s)
    );

    // Next-state, access decode and shadow RAM write selection
    always_comb begin
        state_nxt_s      = state_r;
        cursor_nxt_s     = cursor_addr;
        flags_nxt_s      = flags_r;
        cmd_code_nxt_s   = cmd_code;
        cmd_valid_nxt_s  = 1'b0;
        data_valid_nxt_s = 1'b0;
        unsup_nxt_s      = 1'b0;
        dropped_nxt_s    = 1'b0;
        clr_req_nxt_s    = 1'b0;
        ram_we_s         = 1'b0;
        ram_waddr_s      = clr_idx_r;
        ram_wdata_s      = BLANK_CHAR;
        instr_s          = decode_instr(data_s[7:0]);
        case (state_r)
            ST_CLEARING: begin
                ram_we_s      = 1'b1;
                dropped_nxt_s = strb_s;
                if (clr_idx_r == CELL_W'(CELLS - 1)) state_nxt_s = ST_IDLE;
                else                                 state_nxt_s = ST_CLEARING;
            end
            ST_EXEC: begin
                if (clr_req_r) state_nxt_s = ST_CLEARING;
                else           state_nxt_s = ST_IDLE;
            end
            ST_IDLE: begin
                if (strb_s) begin
                    state_nxt_s = ST_EXEC;
                    if (rw_s) begin
                        unsup_nxt_s = 1'b1;
                    end else if (rs_s) begin
                        data_valid_nxt_s = 1'b1;
                        ram_wdata_s      = data_s[7:0];
                        // Only the visible window of each row is shadowed
                        if (cursor_addr <= 7'(NUM_COLS - 1)) begin
                            ram_we_s    = 1'b1;
                            ram_waddr_s = CELL_W'(cursor_addr);
                        end else if ((cursor_addr >= DDRAM_ROW1_MIN) &&
                                     (cursor_addr <= DDRAM_ROW1_MIN + 7'(NUM_COLS - 1))) begin
                            ram_we_s    = 1'b1;
                            ram_waddr_s = CELL_W'(cursor_addr - DDRAM_ROW1_MIN) + CELL_W'(NUM_COLS);
                        end else begin
                            ram_we_s    = 1'b0;
                        end
                        if (flags_r.entry_inc) cursor_nxt_s = cursor_inc(cursor_addr);
                        else                   cursor_nxt_s = cursor_dec(cursor_addr);
                    end else begin
                        cmd_valid_nxt_s = 1'b1;
                        cmd_code_nxt_s  = data_s[7:0];
                        case (instr_s)
                            I_SET_DDRAM: begin
                                if (ddram_valid(data_s[6:0])) cursor_nxt_s = data_s[6:0];
                                else                          unsup_nxt_s  = 1'b1;
                            end
                            I_FUNC_SET: begin
                                flags_nxt_s.mode_8bit = data_s[4];
                                flags_nxt_s.two_line  = data_s[3];
                            end
                            I_DISP_CTRL: begin
                                flags_nxt_s.display_on = data_s[2];
                                flags_nxt_s.cursor_on  = data_s[1];
                                flags_nxt_s.blink_on   = data_s[0];
                            end
                            I_ENTRY_MODE: begin
                                flags_nxt_s.entry_inc   = data_s[1];
                                flags_nxt_s.entry_shift = data_s[0];
                            end
                            I_HOME: cursor_nxt_s = DDRAM_ROW0_MIN;
                            I_CLEAR: begin
                                cursor_nxt_s          = DDRAM_ROW0_MIN;
                                flags_nxt_s.entry_inc = 1'b1;
                                clr_req_nxt_s         = 1'b1;
                            end
                            default: unsup_nxt_s = 1'b1;
                        endcase
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_CLEARING;
        endcase
    end

    // FSM state, sweep index, cursor, flags and one-cycle event pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_CLEARING;
            clr_idx_r   <= {CELL_W{1'b0}};
            clr_req_r   <= 1'b0;
            cursor_addr <= DDRAM_ROW0_MIN;
            flags_r     <= FLAGS_RESET;
            cmd_code    <= 8'h00;
            cmd_valid   <= 1'b0;
            data_valid  <= 1'b0;
            unsupported <= 1'b0;
            dropped     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            if (state_r == ST_CLEARING) clr_idx_r <= clr_idx_r + CELL_W'(1);
            else                        clr_idx_r <= {CELL_W{1'b0}};
            clr_req_r   <= clr_req_nxt_s;
            cursor_addr <= cursor_nxt_s;
            flags_r     <= flags_nxt_s;
            cmd_code    <= cmd_code_nxt_s;
            cmd_valid   <= cmd_valid_nxt_s;
            data_valid  <= data_valid_nxt_s;
            unsupported <= unsup_nxt_s;
            dropped     <= dropped_nxt_s;
        end
    end

    // Shadow DDRAM write port (clear sweep or character write)
    always_ff @(posedge clk) begin
        if (ram_we_s) ram_r[ram_waddr_s] <= ram_wdata_s;
    end

    // Independent registered read port
    always_ff @(posedge clk) begin
        if (reset) rd_char <= 8'h00;
        else       rd_char <= ram_r[rd_addr];
    end

    assign display_on  = flags_r.display_on;
    assign cursor_on   = flags_r.cursor_on;
    assign blink_on    = flags_r.blink_on;
    assign mode_8bit   = flags_r.mode_8bit;
    assign two_line    = flags_r.two_line;
    assign entry_inc   = flags_r.entry_inc;
    assign entry_shift = flags_r.entry_shift;

`ifdef LCD_RX_BUSY_CHECK_EN
    localparam int BUSY_W = $clog2(BUSY_CYCLES_CLEAR + 1);
    logic [BUSY_W-1:0] busy_cnt_r;

    // Busy countdown after each executed access; early strobes flag an error
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt_r   <= {BUSY_W{1'b0}};
            protocol_err <= 1'b0;
        end else begin
            if (strb_s && (busy_cnt_r != {BUSY_W{1'b0}})) protocol_err <= 1'b1;
            else                                          protocol_err <= protocol_err;
            if ((state_r == ST_IDLE) && strb_s) begin
                if (clr_req_nxt_s) busy_cnt_r <= BUSY_W'(BUSY_CYCLES_CLEAR);
                else               busy_cnt_r <= BUSY_W'(BUSY_CYCLES);
            end else if (busy_cnt_r != {BUSY_W{1'b0}}) begin
                busy_cnt_r <= busy_cnt_r - BUSY_W'(1);
            end else begin
                busy_cnt_r <= busy_cnt_r;
            end
        end
    end
`else
    // Busy checking not built: error flag held low
    always_ff @(posedge clk) begin
        protocol_err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_lcd1602_bus_receiver.sv
// Directed, table-driven bench for lcd1602_bus_receiver.
module tb_lcd1602_bus_receiver;

    logic       clk;
    logic       reset;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic [6:0] cursor_addr;
    logic       display_on, cursor_on, blink_on, mode_8bit, two_line, entry_inc, entry_shift;
    logic       cmd_valid, data_valid, unsupported, dropped, protocol_err;
    logic [7:0] cmd_code;

    lcd1602_bus_receiver_if #(.DATA_BITS(8)) bus ();

    lcd1602_bus_receiver dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .rd_addr      (rd_addr),
        .rd_char      (rd_char),
        .cursor_addr  (cursor_addr),
        .display_on   (display_on),
        .cursor_on    (cursor_on),
        .blink_on     (blink_on),
        .mode_8bit    (mode_8bit),
        .two_line     (two_line),
        .entry_inc    (entry_inc),
        .entry_shift  (entry_shift),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .data_valid   (data_valid),
        .unsupported  (unsupported),
        .dropped      (dropped),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cmd = 0, n_data = 0, n_unsup = 0, n_drop = 0;

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (cmd_valid)   n_cmd++;
        if (data_valid)  n_data++;
        if (unsupported) n_unsup++;
        if (dropped)     n_drop++;
    end

    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] d;
        logic [6:0] cur;
        logic [6:0] flags;   // {disp, cur, blink, 8bit, 2line, inc, shift}
        logic [7:0] code;
        int         dc;
        int         dd;
        int         du;
    } vec_t;

    typedef struct {
        logic [4:0] a;
        logic [7:0] v;
    } cell_t;

    vec_t  vecs  [29];
    cell_t cells [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic rs, input logic rw, input logic [7:0] d, input int post);
        @(negedge clk);
        bus.lcd_rs   = rs;
        bus.lcd_rw   = rw;
        bus.lcd_data = d;
        repeat (2) @(negedge clk);
        bus.lcd_enable = 1'b1;
        repeat (4) @(negedge clk);
        bus.lcd_enable = 1'b0;
        repeat (post) @(negedge clk);
    endtask

    task automatic read_cell(input logic [4:0] a, output logic [7:0] v);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        v = rd_char;
    endtask

    function automatic logic [6:0] flags_now();
        return {display_on, cursor_on, blink_on, mode_8bit, two_line, entry_inc, entry_shift};
    endfunction

    logic [7:0] got;
    int         c0, d0, u0, p0;
    logic       exp_perr;

    initial begin
        vecs = '{
            '{1'b0, 1'b0, 8'h38, 7'h00, 7'b0001110, 8'h38, 1, 0, 0},
            '{1'b0, 1'b0, 8'h06, 7'h00, 7'b0001110, 8'h06, 1, 0, 0},
            '{1'b0, 1'b0, 8'h0C, 7'h00, 7'b1001110, 8'h0C, 1, 0, 0},
            '{1'b0, 1'b0, 8'h01, 7'h00, 7'b1001110, 8'h01, 1, 0, 0},
            '{1'b0, 1'b0, 8'h8B, 7'h0B, 7'b1001110, 8'h8B, 1, 0, 0},
            '{1'b1, 1'b0, 8'h34, 7'h0C, 7'b1001110, 8'h8B, 0, 1, 0},
            '{1'b1, 1'b0, 8'h32, 7'h0D, 7'b1001110, 8'h8B, 0, 1, 0},
            '{1'b0, 1'b0, 8'hA7, 7'h27, 7'b1001110, 8'hA7, 1, 0, 0},
            '{1'b1, 1'b0, 8'h58, 7'h40, 7'b1001110, 8'hA7, 0, 1, 0},
            '{1'b1, 1'b0, 8'h59, 7'h41, 7'b1001110, 8'hA7, 0, 1, 0},
            '{1'b0, 1'b0, 8'h04, 7'h41, 7'b1001100, 8'h04, 1, 0, 0},
            '{1'b0, 1'b0, 8'h80, 7'h00, 7'b1001100, 8'h80, 1, 0, 0},
            '{1'b1, 1'b0, 8'h5A, 7'h67, 7'b1001100, 8'h80, 0, 1, 0},
            '{1'b0, 1'b0, 8'hE8, 7'h67, 7'b1001100, 8'hE8, 1, 0, 1},
            '{1'b1, 1'b1, 8'h41, 7'h67, 7'b1001100, 8'hE8, 0, 0, 1},
            '{1'b0, 1'b0, 8'h40, 7'h67, 7'b1001100, 8'h40, 1, 0, 1},
            '{1'b0, 1'b0, 8'h18, 7'h67, 7'b1001100, 8'h18, 1, 0, 1},
            '{1'b0, 1'b0, 8'h00, 7'h67, 7'b1001100, 8'h00, 1, 0, 1},
            '{1'b0, 1'b0, 8'h07, 7'h67, 7'b1001111, 8'h07, 1, 0, 0},
            '{1'b0, 1'b0, 8'h0F, 7'h67, 7'b1111111, 8'h0F, 1, 0, 0},
            '{1'b0, 1'b0, 8'h02, 7'h00, 7'b1111111, 8'h02, 1, 0, 0},
            '{1'b0, 1'b0, 8'h30, 7'h00, 7'b1111011, 8'h30, 1, 0, 0},
            '{1'b0, 1'b0, 8'h06, 7'h00, 7'b1111010, 8'h06, 1, 0, 0},
            '{1'b1, 1'b0, 8'h41, 7'h01, 7'b1111010, 8'h06, 0, 1, 0},
            '{1'b1, 1'b1, 8'h55, 7'h01, 7'b1111010, 8'h06, 0, 0, 1},
            '{1'b0, 1'b0, 8'hC0, 7'h40, 7'b1111010, 8'hC0, 1, 0, 0},
            '{1'b0, 1'b0, 8'h04, 7'h40, 7'b1111000, 8'h04, 1, 0, 0},
            '{1'b1, 1'b0, 8'h2A, 7'h27, 7'b1111000, 8'h04, 0, 1, 0},
            '{1'b1, 1'b0, 8'h2B, 7'h26, 7'b1111000, 8'h04, 0, 1, 0}
        };
        cells = '{
            '{5'd0,  8'h41}, '{5'd1,  8'h20}, '{5'd11, 8'h34},
            '{5'd12, 8'h32}, '{5'd13, 8'h20}, '{5'd15, 8'h20},
            '{5'd16, 8'h59}, '{5'd17, 8'h20}, '{5'd31, 8'h20}
        };
`ifdef LCD_RX_BUSY_CHECK_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif

        reset          = 1'b1;
        rd_addr        = 5'd0;
        bus.lcd_rs     = 1'b0;
        bus.lcd_rw     = 1'b0;
        bus.lcd_enable = 1'b0;
        bus.lcd_data   = 8'h00;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_rd_char", rd_char, 8'h00);
        check("rst_cursor", cursor_addr, 7'h00);
        check("rst_flags", flags_now(), 7'b0001010);
        check("rst_cmd_code", cmd_code, 8'h00);
        check("rst_pulses", {cmd_valid, data_valid, unsupported, dropped}, 4'b0000);
        check("rst_perr", protocol_err, 1'b0);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        // Initial sweep fills every cell with blanks
        for (int c = 0; c < 32; c++) begin
            read_cell(5'(c), got);
            check("init_blank", got, 8'h20);
        end

        // Directed vector table
        for (int i = 0; i < 29; i++) begin
            c0 = n_cmd; d0 = n_data; u0 = n_unsup;
            bus_write(vecs[i].rs, vecs[i].rw, vecs[i].d, 2);
            repeat (40) @(negedge clk);
            check($sformatf("v%0d_cursor", i), cursor_addr, vecs[i].cur);
            check($sformatf("v%0d_flags", i), flags_now(), vecs[i].flags);
            check($sformatf("v%0d_code", i), cmd_code, vecs[i].code);
            check($sformatf("v%0d_cmd", i), n_cmd - c0, vecs[i].dc);
            check($sformatf("v%0d_data", i), n_data - d0, vecs[i].dd);
            check($sformatf("v%0d_unsup", i), n_unsup - u0, vecs[i].du);
            if (i == 24) begin
                for (int k = 0; k < 9; k++) begin
                    read_cell(cells[k].a, got);
                    check($sformatf("cell%0d", cells[k].a), got, cells[k].v);
                end
            end
        end
        check("no_drops", n_drop, 0);
        read_cell(5'd16, got);
        check("cell16_dec", got, 8'h2A);

        // Strobe during clear sweep is dropped
        c0 = n_cmd; d0 = n_data; p0 = n_drop;
        bus_write(1'b0, 1'b0, 8'h01, 2);
        bus_write(1'b1, 1'b0, 8'h33, 2);
        repeat (40) @(negedge clk);
        check("drop_pulse", n_drop - p0, 1);
        check("drop_cmd", n_cmd - c0, 1);
        check("drop_data", n_data - d0, 0);
        check("drop_cursor", cursor_addr, 7'h00);
        check("drop_flags", flags_now(), 7'b1111010);
        read_cell(5'd0, got);
        check("clr_cell0", got, 8'h20);
        read_cell(5'd11, got);
        check("clr_cell11", got, 8'h20);
        read_cell(5'd16, got);
        check("clr_cell16", got, 8'h20);

        // Reset asserted in the middle of a sweep
        bus_write(1'b0, 1'b0, 8'h01, 2);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_flags", flags_now(), 7'b0001010);
        check("mid_rst_code", cmd_code, 8'h00);
        check("mid_rst_perr", protocol_err, 1'b0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        read_cell(5'd31, got);
        check("mid_rst_cell31", got, 8'h20);

        // Access arriving inside the busy window
        c0 = n_cmd;
        bus_write(1'b0, 1'b0, 8'h38, 2);
        repeat (100) @(negedge clk);
        check("busy_pre_perr", protocol_err, 1'b0);
        bus_write(1'b0, 1'b0, 8'h06, 2);
        repeat (10) @(negedge clk);
        check("busy_perr", protocol_err, exp_perr);
        check("busy_exec", n_cmd - c0, 2);
        check("busy_two_line", two_line, 1'b1);
        repeat (50) @(negedge clk);
        check("busy_perr_hold", protocol_err, exp_perr);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("busy_perr_rst", protocol_err, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
